// File: rtl/ctrl_pkg.sv
// Shared decode constants for the decode/control stage: opcode and funct
// codes, ALU select encodings, control-flag layout and the NOP flag bundle.
package ctrl_pkg;

  localparam logic [5:0] OP_JMP   = 6'd2;
  localparam logic [5:0] OP_RTYPE = 6'd12;
  localparam logic [5:0] OP_LW    = 6'd34;
  localparam logic [5:0] OP_SW    = 6'd35;
  localparam logic [5:0] OP_BNE   = 6'd36;
  localparam logic [5:0] OP_ADDI  = 6'd37;
  localparam logic [5:0] OP_ORI   = 6'd38;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_MUL = 6'd50;

  localparam logic [1:0] ALU_SEL_ADD = 2'b00;
  localparam logic [1:0] ALU_SEL_SUB = 2'b01;
  localparam logic [1:0] ALU_SEL_OR  = 2'b11;

  // Bit positions of the flags in the low part of ctrl_out; the register
  // indices rd, rt, rs follow above CTRL_FLAG_W in that order.
  localparam int CTRL_JMP_BIT       = 0;
  localparam int CTRL_BRANCH_BIT    = 1;
  localparam int CTRL_CS_WB2_BIT    = 2;
  localparam int CTRL_WR_MEM_BIT    = 3;
  localparam int CTRL_MUX2_ALU_BIT  = 4;
  localparam int CTRL_MUL_START_BIT = 5;
  localparam int CTRL_ALU_SEL_LSB   = 6;
  localparam int CTRL_MUX_IMM_BIT   = 8;
  localparam int CTRL_WR_REG_BIT    = 9;
  localparam int CTRL_FLAG_W        = 10;

  typedef struct packed {
    logic       wr_regfile;
    logic       mux_imm;
    logic [1:0] alu_sel;
    logic       mul_start;
    logic       mux2_alu;
    logic       wr_mem;
    logic       cs_wb_2;
    logic       branch_flag;
    logic       jmp_flag;
  } ctrl_flags_t;

  localparam ctrl_flags_t CTRL_NOP_FLAGS = '{
    wr_regfile: 1'b0, mux_imm: 1'b0, alu_sel: ALU_SEL_ADD, mul_start: 1'b0,
    mux2_alu: 1'b1, wr_mem: 1'b0, cs_wb_2: 1'b0, branch_flag: 1'b0, jmp_flag: 1'b0
  };

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decoder: register fields, control flags and
// the per-instruction attributes the hazard logic needs.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5
) (
  input  logic [INSTR_W-1:0]     instr,
  output logic [REG_AW-1:0]      rs,
  output logic [REG_AW-1:0]      rt,
  output logic [REG_AW-1:0]      rd,
  output logic [CTRL_FLAG_W-1:0] flags,
  output logic                   legal,
  output logic                   is_load,
  output logic                   is_store,
  output logic                   is_mul,
  output logic                   writes_reg,
  output logic                   reads_rt
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  ctrl_flags_t f;
  logic        unused_bits;

  assign opcode = instr[INSTR_W-1 -: 6];
  assign funct  = instr[5:0];
  assign rs     = instr[21 +: REG_AW];
  assign rt     = instr[16 +: REG_AW];
  // Immediate and shamt bits only travel through the fields above.
  assign unused_bits = ^instr;

  // Opcode/funct to flag bundle; anything not recognised stays a NOP.
  always_comb begin
    f        = CTRL_NOP_FLAGS;
    rd       = instr[11 +: REG_AW];
    legal    = 1'b1;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_mul   = 1'b0;
    reads_rt = 1'b0;
    case (opcode)
      OP_LW: begin
        f.wr_regfile = 1'b1;
        f.mux_imm    = 1'b1;
        f.cs_wb_2    = 1'b1;
        f.alu_sel    = ALU_SEL_ADD;
        rd           = rt;
        is_load      = 1'b1;
      end
      OP_ADDI, OP_ORI: begin
        f.wr_regfile = 1'b1;
        f.mux_imm    = 1'b1;
        f.cs_wb_2    = 1'b1;
        f.alu_sel    = (opcode == OP_ORI) ? ALU_SEL_OR : ALU_SEL_ADD;
        rd           = rt;
      end
      OP_SW: begin
        f.wr_mem  = 1'b1;
        f.mux_imm = 1'b1;
        is_store  = 1'b1;
        reads_rt  = 1'b1;
      end
      OP_BNE: begin
        f.alu_sel     = ALU_SEL_SUB;
        f.branch_flag = 1'b1;
        reads_rt      = 1'b1;
      end
      OP_JMP: f.jmp_flag = 1'b1;
      OP_RTYPE: begin
        reads_rt = 1'b1;
        case (funct)
          FN_ADD: f.wr_regfile = 1'b1;
          FN_SUB: begin
            f.wr_regfile = 1'b1;
            f.alu_sel    = ALU_SEL_SUB;
          end
          FN_MUL: begin
            f.wr_regfile = 1'b1;
            f.mux2_alu   = 1'b0;
            f.mul_start  = 1'b1;
            is_mul       = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  assign flags      = f;
  assign writes_reg = f.wr_regfile;

endmodule

// File: rtl/control_pipe.sv
// Registered decode/control stage between fetch and execute: one output
// register, load-use interlock, multiplier scoreboard and flush.
// Optional build macro CTRL_ILLEGAL_TRAP_EN adds the sticky `illegal` port and
// freezes intake after an undecodable instruction until reset.
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTR_W-1:0]            instr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3*REG_AW+CTRL_FLAG_W-1:0] ctrl_out,
  output logic                          mul_busy
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                          illegal
`endif
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  logic [REG_AW-1:0]      d_rs, d_rt, d_rd;
  logic [CTRL_FLAG_W-1:0] d_flags;
  logic d_legal, d_is_load, d_is_store, d_is_mul, d_writes_reg, d_reads_rt;

  logic [REG_AW-1:0] ld_tag;
  logic [REG_AW-1:0] mul_tag;
  logic [CNT_W-1:0]  mul_cnt;
  logic lu_hit, mul_hit, stall, accept, trap_hold;

  ctrl_decode #(.INSTR_W(INSTR_W), .REG_AW(REG_AW)) u_decode (
    .instr      (instr),
    .rs         (d_rs),
    .rt         (d_rt),
    .rd         (d_rd),
    .flags      (d_flags),
    .legal      (d_legal),
    .is_load    (d_is_load),
    .is_store   (d_is_store),
    .is_mul     (d_is_mul),
    .writes_reg (d_writes_reg),
    .reads_rt   (d_reads_rt)
  );

  assign mul_busy = (mul_cnt != '0);

  // Hazards against the pending load tag and the in-flight multiply.
  // A zero tag means "no dependency", so register 0 never stalls.
  always_comb begin
    lu_hit  = 1'b0;
    mul_hit = 1'b0;
    if (in_valid && (ld_tag != '0))
      lu_hit = (d_rs == ld_tag) || (d_reads_rt && (d_rt == ld_tag));
    if (in_valid && mul_busy)
      mul_hit = d_is_mul || d_is_load || d_is_store ||
                ((mul_tag != '0) &&
                 ((d_rs == mul_tag) || (d_reads_rt && (d_rt == mul_tag)) ||
                  (d_writes_reg && (d_rd == mul_tag))));
  end

  assign stall = lu_hit | mul_hit;

  // Handshake: a word moves on a port only in a cycle where valid and ready
  // are both high at the rising edge. in_ready may depend on in_valid/instr
  // (hazard check), while out_valid is purely registered; once out_valid is
  // high, ctrl_out stays unchanged until out_ready is seen or flush kills it.
  assign in_ready = (!out_valid || out_ready) && !stall && !flush && !trap_hold;
  assign accept   = in_valid && in_ready;

  // Output register: load on accept, drain when execute takes the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_out  <= {{(3*REG_AW){1'b0}}, CTRL_NOP_FLAGS};
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl_out  <= {d_rs, d_rt, d_rd, d_flags};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Load tag lives for exactly one accepted slot or one stall cycle.
  always_ff @(posedge clk) begin
    if (rst || flush)
      ld_tag <= '0;
    else if (accept)
      ld_tag <= d_is_load ? d_rd : '0;
    else if (lu_hit)
      ld_tag <= '0;
  end

  // Multiplier scoreboard; flush does not stop it because the mul already left.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt <= '0;
      mul_tag <= '0;
    end else if (accept && d_is_mul) begin
      mul_cnt <= MUL_LOAD;
      mul_tag <= d_rd;
    end else if (mul_cnt != '0) begin
      mul_cnt <= mul_cnt - CNT_W'(1);
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky trap: an undecodable word goes out as a NOP, then intake stops.
  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (accept && !d_legal)
      illegal_q <= 1'b1;
  end

  assign illegal   = illegal_q;
  assign trap_hold = illegal_q;
`else
  logic unused_legal;
  assign unused_legal = d_legal;
  assign trap_hold    = 1'b0;
`endif

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: reset checks, a decode vector table, directed
// multi-cycle sequences and a randomized run against a cycle reference model.
module tb_control_pipe;

  localparam int REG_AW     = 5;
  localparam int MUL_CYCLES = 4;
  localparam int CW         = 3*REG_AW + 10;

  // Flag fields: wr_regfile, mux_imm, alu_sel[1:0], mul_start, mux2_alu,
  // wr_mem, cs_wb_2, branch_flag, jmp_flag
  localparam logic [9:0] F_LW   = 10'b11_00_0_1_0_1_0_0;
  localparam logic [9:0] F_ADDI = 10'b11_00_0_1_0_1_0_0;
  localparam logic [9:0] F_ORI  = 10'b11_11_0_1_0_1_0_0;
  localparam logic [9:0] F_SW   = 10'b01_00_0_1_1_0_0_0;
  localparam logic [9:0] F_BNE  = 10'b00_01_0_1_0_0_1_0;
  localparam logic [9:0] F_JMP  = 10'b00_00_0_1_0_0_0_1;
  localparam logic [9:0] F_ADD  = 10'b10_00_0_1_0_0_0_0;
  localparam logic [9:0] F_SUB  = 10'b10_01_0_1_0_0_0_0;
  localparam logic [9:0] F_MUL  = 10'b10_00_1_0_0_0_0_0;
  localparam logic [9:0] F_NOP  = 10'b00_00_0_1_0_0_0_0;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready, mul_busy;
  logic [31:0]   instr;
  logic [CW-1:0] ctrl_out;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0]   instr;
    logic [CW-1:0] exp;
    logic          bad;
  } vec_t;
  vec_t vecs[11];

  logic [CW-1:0] exp_q[$];

  control_pipe #(.INSTR_W(32), .REG_AW(REG_AW), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ctrl_out  (ctrl_out),
    .mul_busy  (mul_busy)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal   (illegal)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish before 500000");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int fn);
    return {6'd12, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  function automatic logic [CW-1:0] bundle(input int rs, input int rt, input int rd, input logic [9:0] f);
    return {rs[4:0], rt[4:0], rd[4:0], f};
  endfunction

  // Reference decode built directly from the instruction-set rules.
  function automatic logic [CW-1:0] model_decode(input logic [31:0] i);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic wr, mi, ms, m2, wm, cs, br, jp;
    logic [1:0] alu;
    op = i[31:26]; fn = i[5:0];
    rs = i[25:21]; rt = i[20:16]; rd = i[15:11];
    wr = 0; mi = 0; ms = 0; m2 = 1; wm = 0; cs = 0; br = 0; jp = 0; alu = 2'b00;
    if (op == 34 || op == 37 || op == 38) begin
      rd = rt; mi = 1; cs = 1; wr = 1; alu = (op == 38) ? 2'b11 : 2'b00;
    end else if (op == 35) begin
      wm = 1; mi = 1;
    end else if (op == 36) begin
      alu = 2'b01; br = 1;
    end else if (op == 2) begin
      jp = 1;
    end else if (op == 12 && fn == 32) begin
      wr = 1;
    end else if (op == 12 && fn == 34) begin
      wr = 1; alu = 2'b01;
    end else if (op == 12 && fn == 50) begin
      wr = 1; m2 = 0; ms = 1;
    end
    return {rs, rt, rd, wr, mi, alu, ms, m2, wm, cs, br, jp};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k, a, b, c;
    k = $urandom_range(0, 10);
    a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
    case (k)
      0: return i_ins(34, a, b, $urandom_range(0, 65535));
      1: return i_ins(35, a, b, $urandom_range(0, 65535));
      2: return i_ins(36, a, b, $urandom_range(0, 65535));
      3: return i_ins(37, a, b, $urandom_range(0, 65535));
      4: return i_ins(38, a, b, $urandom_range(0, 65535));
      5: return {6'd2, 26'($urandom())};
      6: return r_ins(a, b, c, 32);
      7: return r_ins(a, b, c, 34);
      8, 9: return r_ins(a, b, c, 50);
`ifdef CTRL_ILLEGAL_TRAP_EN
      default: return r_ins(a, b, c, 32);
`else
      default: return i_ins(63, a, b, $urandom_range(0, 65535));
`endif
    endcase
  endfunction

  // ---------------- random-phase model state ----------------
  int cyc, mul_at;
  logic [4:0] ld_tag_m, mul_dst_m;
  logic pend;
  logic [31:0] cur;
  logic [5:0] m_op, m_fn;
  logic [4:0] m_rs, m_rt, m_rd, m_dst;
  logic m_ld, m_st, m_mul, m_rrt, m_busy, m_lu, m_mh, m_rdy;
  int stalls;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
    tick();

    // Decode vector table
    vecs[0]  = '{i_ins(37, 0, 1, 5),                       bundle(0, 1, 1, F_ADDI), 1'b0};
    vecs[1]  = '{i_ins(34, 3, 2, 8),                       bundle(3, 2, 2, F_LW),   1'b0};
    vecs[2]  = '{i_ins(38, 5, 4, 16'h00ff),                bundle(5, 4, 4, F_ORI),  1'b0};
    vecs[3]  = '{i_ins(35, 7, 6, 16'h1808),                bundle(7, 6, 3, F_SW),   1'b0};
    vecs[4]  = '{i_ins(36, 8, 9, 16'h0010),                bundle(8, 9, 0, F_BNE),  1'b0};
    vecs[5]  = '{32'h0800_1234,                            bundle(0, 0, 2, F_JMP),  1'b0};
    vecs[6]  = '{r_ins(1, 2, 3, 32),                       bundle(1, 2, 3, F_ADD),  1'b0};
    vecs[7]  = '{r_ins(11, 12, 10, 34),                    bundle(11, 12, 10, F_SUB), 1'b0};
    vecs[8]  = '{r_ins(14, 15, 13, 50),                    bundle(14, 15, 13, F_MUL), 1'b0};
    vecs[9]  = '{{6'd63, 5'd1, 5'd2, 5'd3, 11'd0},         bundle(1, 2, 3, F_NOP),  1'b1};
    vecs[10] = '{r_ins(4, 5, 6, 7),                        bundle(4, 5, 6, F_NOP),  1'b1};

    // Reset state
    do_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_ctrl_out", ctrl_out, bundle(0, 0, 0, F_NOP));
    check("rst_mul_busy", mul_busy, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("rst_illegal", illegal, 0);
`endif

    for (int v = 0; v < 11; v++) begin
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; instr = vecs[v].instr;
      #1;
      check($sformatf("vec%0d_in_ready", v), in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_out_valid", v), out_valid, 1);
      check($sformatf("vec%0d_ctrl_out", v), ctrl_out, vecs[v].exp);
`ifdef CTRL_ILLEGAL_TRAP_EN
      check($sformatf("vec%0d_illegal", v), illegal, vecs[v].bad);
`endif
    end

    // Load-use: lw r2 ; add r3,r2,r4 -> one bubble
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; instr = i_ins(34, 0, 2, 0);
    #1;
    check("lu_lw_ready", in_ready, 1);
    tick();
    instr = r_ins(2, 4, 3, 32);
    #1;
    check("lu_bubble_ready", in_ready, 0);
    check("lu_lw_out", ctrl_out, bundle(0, 2, 2, F_LW));
    tick();
    #1;
    check("lu_release_ready", in_ready, 1);
    check("lu_gap_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    #1;
    check("lu_add_out", ctrl_out, bundle(2, 4, 3, F_ADD));
    check("lu_add_valid", out_valid, 1);

    // Multiply RAW: add r8,r5,r1 waits for the mul to r5
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; instr = r_ins(6, 7, 5, 50);
    #1;
    check("mul_issue_ready", in_ready, 1);
    tick();
    instr = r_ins(5, 1, 8, 32);
    #1;
    check("mul_busy_after_issue", mul_busy, 1);
    stalls = 0;
    while (in_ready !== 1'b1 && stalls < 10) begin
      tick();
      #1;
      stalls++;
    end
    check("mul_raw_stall_cycles", stalls, MUL_CYCLES - 1);
    check("mul_busy_at_release", mul_busy, 0);
    tick();
    in_valid = 1'b0;
    #1;
    check("mul_raw_out", ctrl_out, bundle(5, 1, 8, F_ADD));
    // Independent add issues under a busy multiplier
    in_valid = 1'b1; instr = r_ins(6, 7, 5, 50);
    #1;
    tick();
    instr = r_ins(1, 2, 9, 32);
    #1;
    check("mul_indep_busy", mul_busy, 1);
    check("mul_indep_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    check("mul_indep_out", ctrl_out, bundle(1, 2, 9, F_ADD));

    // Back-pressure: sub held three cycles
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; instr = r_ins(2, 3, 1, 34);
    #1;
    check("bp_first_ready", in_ready, 1);
    tick();
    instr = i_ins(37, 0, 7, 9);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_hold%0d_valid", k), out_valid, 1);
      check($sformatf("bp_hold%0d_ctrl", k), ctrl_out, bundle(2, 3, 1, F_SUB));
      check($sformatf("bp_hold%0d_ready", k), in_ready, 0);
      tick();
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_drain_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    check("bp_next_ctrl", ctrl_out, bundle(0, 7, 7, F_ADDI));
    check("bp_next_valid", out_valid, 1);
    tick();
    #1;
    check("bp_no_dup", out_valid, 0);

    // Flush with output held and input pending; also clears the load tag
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; instr = i_ins(34, 0, 2, 0);
    #1;
    tick();
    instr = r_ins(2, 4, 3, 32); flush = 1'b1;
    #1;
    check("fl_ready", in_ready, 0);
    check("fl_valid_before", out_valid, 1);
    tick();
    flush = 1'b0; out_ready = 1'b1;
    #1;
    check("fl_valid_after", out_valid, 0);
    check("fl_tag_cleared", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    check("fl_add_valid", out_valid, 1);
    check("fl_add_ctrl", ctrl_out, bundle(2, 4, 3, F_ADD));
    tick();
    #1;
    check("fl_add_once", out_valid, 0);

    // Undecodable word followed by a legal one
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; instr = {6'd63, 26'd0};
    #1;
    tick();
    instr = i_ins(37, 0, 1, 1);
    #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      check($sformatf("trap_hold%0d_ready", k), in_ready, 0);
      check($sformatf("trap_hold%0d_flag", k), illegal, 1);
      tick();
      #1;
    end
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; instr = i_ins(37, 0, 1, 1);
    #1;
    check("trap_rst_flag", illegal, 0);
    check("trap_rst_ready", in_ready, 1);
`else
    check("illegal_flow_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    check("illegal_flow_ctrl", ctrl_out, bundle(0, 1, 1, F_ADDI));
`endif

    // Reset in the middle of a multiply
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; instr = r_ins(1, 2, 3, 50);
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    check("rstmul_busy_before", mul_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstmul_busy_after", mul_busy, 0);
    check("rstmul_valid_after", out_valid, 0);

    // Randomized run against the cycle model
    do_reset();
    cyc = 0; mul_at = -1000; ld_tag_m = '0; mul_dst_m = '0; pend = 1'b0; cur = '0;
    exp_q.delete();
    for (int n = 0; n < 1500; n++) begin
      if (!pend && $urandom_range(0, 99) < 70) begin
        pend = 1'b1;
        cur  = rand_instr();
      end
      in_valid  = pend;
      instr     = pend ? cur : $urandom();
      out_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 99) < 4);
      #1;

      m_op = cur[31:26]; m_fn = cur[5:0];
      m_rs = cur[25:21]; m_rt = cur[20:16]; m_rd = cur[15:11];
      m_ld  = (m_op == 34);
      m_st  = (m_op == 35);
      m_mul = (m_op == 12 && m_fn == 50);
      m_rrt = (m_op == 12 || m_op == 35 || m_op == 36);
      if (m_op == 34 || m_op == 37 || m_op == 38) m_dst = m_rt;
      else if (m_op == 12 && (m_fn == 32 || m_fn == 34 || m_fn == 50)) m_dst = m_rd;
      else m_dst = '0;
      m_busy = (cyc > mul_at) && (cyc < mul_at + MUL_CYCLES);
      m_lu = pend && (ld_tag_m != 0) && (m_rs == ld_tag_m || (m_rrt && m_rt == ld_tag_m));
      m_mh = pend && m_busy &&
             (m_mul || m_ld || m_st ||
              (mul_dst_m != 0 && (m_rs == mul_dst_m || (m_rrt && m_rt == mul_dst_m) || m_dst == mul_dst_m)));
      m_rdy = (exp_q.size() == 0 || out_ready) && !m_lu && !m_mh && !flush;

      check("rnd_in_ready", in_ready, m_rdy);
      check("rnd_out_valid", out_valid, exp_q.size() != 0);
      check("rnd_mul_busy", mul_busy, m_busy);
      if (exp_q.size() != 0) check("rnd_ctrl_out", ctrl_out, exp_q[0]);

      if (flush) begin
        exp_q.delete();
        ld_tag_m = '0;
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (pend && m_rdy) begin
          exp_q.push_back(model_decode(cur));
          ld_tag_m = m_ld ? m_rt : 5'd0;
          if (m_mul) begin
            mul_at    = cyc;
            mul_dst_m = m_rd;
          end
        end else if (m_lu) begin
          ld_tag_m = '0;
        end
      end
      if (flush || (pend && m_rdy)) pend = 1'b0;
      tick();
      cyc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
